// File: rtl/mult_div_pkg.sv
// Shared state encoding and default sizing for the multiply/divide unit.
package mult_div_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 6;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StMult   = 3'd1,
        StDiv    = 3'd2,
        StDivFix = 3'd3,
        StDone   = 3'd4
    } state_e;

endpackage

// File: rtl/div_core.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        // Top bit of diff is the borrow: set means the divisor did not fit.
        if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed mult (radix-2 Booth) / div (restoring) unit owning the HI/LO registers.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] A_In,
    input  logic [WIDTH-1:0] B_In,
    output logic [WIDTH-1:0] HI_Out,
    output logic [WIDTH-1:0] LO_Out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     prod_hi_q, prod_hi_d;
    logic [WIDTH-1:0]   prod_lo_q, prod_lo_d;
    logic               booth_q_q, booth_q_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic [WIDTH:0]     mcand_ext;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     booth_hi;
    logic [WIDTH-1:0]   booth_lo;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic               last_step;

    div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (rem_step),
        .quo_o     (quo_step)
    );

    // Booth step on {hi (WIDTH+1, sign-extended), lo, q-1}, then arithmetic shift right.
    always_comb begin
        mcand_ext = {mcand_q[WIDTH-1], mcand_q};
        unique case ({prod_lo_q[0], booth_q_q})
            2'b01:   booth_sum = prod_hi_q + mcand_ext;
            2'b10:   booth_sum = prod_hi_q - mcand_ext;
            default: booth_sum = prod_hi_q;
        endcase
        booth_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_lo = {booth_sum[0], prod_lo_q[WIDTH-1:1]};
    end

    assign a_abs     = A_In[WIDTH-1] ? -A_In : A_In;
    assign b_abs     = B_In[WIDTH-1] ? -B_In : B_In;
    assign last_step = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prod_hi_d  = prod_hi_q;
        prod_lo_d  = prod_lo_q;
        booth_q_d  = booth_q_q;
        mcand_d    = mcand_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_mult) begin
                    mcand_d   = A_In;
                    prod_hi_d = '0;
                    prod_lo_d = B_In;
                    booth_q_d = 1'b0;
                    cnt_d     = CNT_W'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = StMult;
                end else if (start_div) begin
                    if (B_In == '0) begin
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        rem_d     = '0;
                        quo_d     = a_abs;
                        divisor_d = b_abs;
                        sign_a_d  = A_In[WIDTH-1];
                        sign_b_d  = B_In[WIDTH-1];
                        cnt_d     = CNT_W'(WIDTH);
                        busy_d    = 1'b1;
                        state_d   = StDiv;
                    end
                end
            end
            StMult: begin
                prod_hi_d = booth_hi;
                prod_lo_d = booth_lo;
                booth_q_d = prod_lo_q[0];
                cnt_d     = cnt_q - CNT_W'(1);
                if (last_step) begin
                    hi_d    = booth_hi[WIDTH-1:0];
                    lo_d    = booth_lo;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    busy_d = 1'b1;
                end
            end
            StDiv: begin
                rem_d  = rem_step;
                quo_d  = quo_step;
                cnt_d  = cnt_q - CNT_W'(1);
                busy_d = 1'b1;
                if (last_step) begin
                    state_d = StDivFix;
                end
            end
            StDivFix: begin
                // Quotient truncates toward zero; remainder follows the dividend's sign.
                lo_d    = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
                hi_d    = sign_a_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            prod_hi_q  <= '0;
            prod_lo_q  <= '0;
            booth_q_q  <= 1'b0;
            mcand_q    <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prod_hi_q  <= prod_hi_d;
            prod_lo_q  <= prod_lo_d;
            booth_q_q  <= booth_q_d;
            mcand_q    <= mcand_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign HI_Out   = hi_q;
    assign LO_Out   = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with latency windows, directed and random ops.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start_mult = 1'b0;
    logic          start_div = 1'b0;
    logic [W-1:0]  A_In = '0;
    logic [W-1:0]  B_In = '0;
    logic [W-1:0]  HI_Out;
    logic [W-1:0]  LO_Out;
    logic          busy;
    logic          done;
    logic          div_zero;

    int tests = 0;
    int fails = 0;

    mult_div_unit #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .A_In       (A_In),
        .B_In       (B_In),
        .HI_Out     (HI_Out),
        .LO_Out     (LO_Out),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op at edge s ends with done after edge s+len-1, where the
    // result (if any) lands; further starts are ignored through edge s+len.
    int          cyc = 0;
    int          end_e = 0;
    int          op_s = 0;
    int          op_len = 0;
    bit          op_dz = 1'b0;
    bit          have_op = 1'b0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic [31:0] pend_hi = '0;
    logic [31:0] pend_lo = '0;
    bit          cmp_en = 1'b0;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q = sa / sb;
        longint r = sa % sb;
        logic [63:0] qv = 64'(q);
        logic [63:0] rv = 64'(r);
        return {rv[31:0], qv[31:0]};
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc     = 0;
            end_e   = 0;
            have_op = 1'b0;
            exp_hi  = '0;
            exp_lo  = '0;
        end else begin
            logic [63:0] r;
            cyc++;
            if (have_op && !op_dz && cyc == op_s + op_len - 1) begin
                exp_hi = pend_hi;
                exp_lo = pend_lo;
            end
            if (cyc > end_e && (start_mult || start_div)) begin
                have_op = 1'b1;
                op_s    = cyc;
                op_dz   = 1'b0;
                if (start_mult) begin
                    r      = ref_mul(A_In, B_In);
                    op_len = W + 1;
                end else if (B_In == '0) begin
                    r      = {exp_hi, exp_lo};
                    op_len = 1;
                    op_dz  = 1'b1;
                end else begin
                    r      = ref_div(A_In, B_In);
                    op_len = W + 2;
                end
                pend_hi = r[63:32];
                pend_lo = r[31:0];
                end_e   = cyc + op_len;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            logic e_busy, e_done;
            e_busy = have_op && !op_dz && cyc >= op_s && cyc < op_s + op_len - 1;
            e_done = have_op && cyc == op_s + op_len - 1;
            check("hi", 64'(HI_Out), 64'(exp_hi));
            check("lo", 64'(LO_Out), 64'(exp_lo));
            check("busy", 64'(busy), 64'(e_busy));
            check("done", 64'(done), 64'(e_done));
            check("div_zero", 64'(div_zero), 64'(e_done && op_dz));
        end
    end

    task automatic do_op(input string name, input logic sm, input logic sd,
                         input logic [31:0] a, input logic [31:0] b, input int lat,
                         input logic [31:0] ehi, input logic [31:0] elo, input int poke);
        int n;
        int nbusy;
        @(negedge clock);
        start_mult = sm;
        start_div  = sd;
        A_In       = a;
        B_In       = b;
        @(negedge clock);
        start_mult = 1'b0;
        start_div  = 1'b0;
        A_In       = $urandom;
        B_In       = $urandom;
        n     = 1;
        nbusy = 0;
        while (!done && n < 100) begin
            if (busy) nbusy++;
            @(negedge clock);
            start_div = 1'b0;
            n++;
            if (n == poke) begin
                start_div = 1'b1;
                A_In      = $urandom;
                B_In      = $urandom_range(1, 50);
            end
        end
        start_div = 1'b0;
        check({name, " latency"}, 64'(n), 64'(lat));
        check({name, " busy cycles"}, 64'(nbusy), 64'(lat - 1));
        check({name, " HI"}, 64'(HI_Out), 64'(ehi));
        check({name, " LO"}, 64'(LO_Out), 64'(elo));
        @(negedge clock);
    endtask

    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, INT_MIN, 32'h7FFF_FFFF, 32'h7};

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int ndone;
        #1 reset = 1'b0;
        #1;
        check("reset HI", 64'(HI_Out), 64'h0);
        check("reset LO", 64'(LO_Out), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset done", 64'(done), 64'h0);
        check("reset div_zero", 64'(div_zero), 64'h0);
        cmp_en = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        do_op("mult 7*-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        do_op("mult min*min", 1, 0, INT_MIN, INT_MIN, 33, 32'h4000_0000, 32'h0, 0);
        do_op("div -7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        do_op("div 100/7", 0, 1, 32'd100, 32'd7, 34, 32'd2, 32'd14, 0);
        do_op("div min/-1", 0, 1, INT_MIN, 32'hFFFF_FFFF, 34, 32'h0, INT_MIN, 0);
        do_op("both starts", 1, 1, 32'd9, 32'd4, 33, 32'h0, 32'd36, 0);
        do_op("preload", 1, 0, 32'd6, 32'h2AAA_AAAB, 33, 32'd1, 32'd2, 0);
        do_op("div by zero", 0, 1, 32'd100, 32'd0, 1, 32'd1, 32'd2, 0);
        do_op("mult 5*6 poked", 1, 0, 32'd5, 32'd6, 33, 32'h0, 32'd30, 10);
        ndone = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check("no second done", 64'(ndone), 64'h0);

        // Abort a divide with an asynchronous reset between clock edges.
        @(negedge clock);
        start_div = 1'b1;
        A_In      = 32'd1000;
        B_In      = 32'd3;
        @(negedge clock);
        start_div = 1'b0;
        repeat (10) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort HI", 64'(HI_Out), 64'h0);
        check("abort LO", 64'(LO_Out), 64'h0);
        check("abort busy", 64'(busy), 64'h0);
        check("abort done", 64'(done), 64'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        do_op("mult 2*3 after reset", 1, 0, 32'd2, 32'd3, 33, 32'h0, 32'd6, 0);

        // Random traffic, including starts while busy or in the done cycle.
        repeat (3000) begin
            int r;
            @(negedge clock);
            r          = $urandom_range(0, 11);
            start_mult = (r == 0);
            start_div  = (r == 1) || (r == 2);
            A_In       = pick_operand();
            B_In       = ($urandom_range(0, 7) == 0) ? 32'h0 : pick_operand();
        end
        @(negedge clock);
        start_mult = 1'b0;
        start_div  = 1'b0;
        repeat (40) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
